// File: rtl/pool_pkg.sv
// Shared constants for the pooling/flatten engine: memory selects, FSM states
// and default geometry of the layer-0 maps.
package pool_pkg;

  localparam int DATA_W_DEF   = 20;
  localparam int ADDR_W_DEF   = 12;
  localparam int MAP_LOG2_DEF = 6;
  localparam int POOL_EDGE    = 32;
  localparam int POOL_PIXELS  = POOL_EDGE * POOL_EDGE;

  localparam logic [2:0] CSEL_NONE  = 3'b000;
  localparam logic [2:0] CSEL_L0_K0 = 3'b001;
  localparam logic [2:0] CSEL_L0_K1 = 3'b010;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2    = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_PEND,
    S_WL1,
    S_WL2,
    S_DONE
  } state_t;

endpackage

// File: rtl/pool_flatten_if.sv
// Shared CNN memory port: one read channel, one write channel and the csel
// bank select that qualifies whichever strobe is active.
interface pool_flatten_if
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Window/pixel/kernel counters for the pooling traversal. Addresses are
// produced from the next-cycle counter values so the top can register them.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAP_LOG2 = MAP_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step_j,
  input  logic              step_k,
  input  logic              step_pix,
  output logic [1:0]        j,
  output logic              k,
  output logic              k_nxt,
  output logic              last_j,
  output logic              last_pix,
  output logic [ADDR_W-1:0] rd_addr_nxt,
  output logic [ADDR_W-1:0] l1_addr_nxt,
  output logic [ADDR_W-1:0] l2_addr_nxt
);

  localparam int PW = MAP_LOG2 - 1;
  localparam logic [2*PW-1:0] PIX_ONE = 1;

  // i = {py, px}; incrementing it walks the pooled map row-major
  logic [2*PW-1:0] i, i_n;
  logic [1:0]      j_n;

  always_comb begin
    j_n = j;
    k_nxt = k;
    i_n = i;
    if (clr) begin
      j_n = 2'd0;
      k_nxt = 1'b0;
      i_n = '0;
    end else begin
      if (step_j) j_n = j + 2'd1;
      if (step_k) k_nxt = 1'b1;
      if (step_pix) begin
        i_n = i + PIX_ONE;
        k_nxt = 1'b0;
      end
    end
  end

  assign rd_addr_nxt = ADDR_W'({i_n[2*PW-1:PW], j_n[1], i_n[PW-1:0], j_n[0]});
  assign l1_addr_nxt = ADDR_W'(i_n);
  assign l2_addr_nxt = ADDR_W'({i_n, k_nxt});
  assign last_j      = (j == 2'd3);
  assign last_pix    = &i;

  always_ff @(posedge clk) begin
    if (reset) begin
      i <= '0;
      j <= 2'd0;
      k <= 1'b0;
    end else begin
      i <= i_n;
      j <= j_n;
      k <= k_nxt;
    end
  end

endmodule

// File: rtl/pool_flatten.sv
// 2x2 stride-2 max-pool of both layer-0 maps, writing the pooled maps to L1
// and the kernel-interleaved flatten vector to L2 over the shared memory port.
module pool_flatten
  import pool_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAP_LOG2 = MAP_LOG2_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  pool_flatten_if.master mem
);

  state_t cs, ns;
  logic              clr, step_j, step_k, step_pix;
  logic [1:0]        j;
  logic              k, k_nxt, last_j, last_pix;
  logic [ADDR_W-1:0] rd_addr_nxt, l1_addr_nxt, l2_addr_nxt;
  logic [DATA_W-1:0] max_q, max_n;
  logic [2:0]        csel_n;

  pool_addr_gen #(.ADDR_W(ADDR_W), .MAP_LOG2(MAP_LOG2)) u_addr (
    .clk(clk), .reset(reset), .clr(clr), .step_j(step_j), .step_k(step_k),
    .step_pix(step_pix), .j(j), .k(k), .k_nxt(k_nxt), .last_j(last_j),
    .last_pix(last_pix), .rd_addr_nxt(rd_addr_nxt), .l1_addr_nxt(l1_addr_nxt),
    .l2_addr_nxt(l2_addr_nxt)
  );

  always_comb begin
    ns = cs;
    clr = 1'b0;
    step_j = 1'b0;
    step_k = 1'b0;
    step_pix = 1'b0;
    case (cs)
      S_IDLE: if (start) begin
        ns = S_RD;
        clr = 1'b1;
      end
      S_RD: begin
        step_j = 1'b1;
        if (last_j) ns = S_PEND;
      end
      S_PEND: ns = S_WL1;
      S_WL1:  ns = S_WL2;
      S_WL2: begin
        if (!k) begin
          step_k = 1'b1;
          ns = S_RD;
        end else if (!last_pix) begin
          step_pix = 1'b1;
          ns = S_RD;
        end else begin
          ns = S_DONE;
        end
      end
      S_DONE:  ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
  end

  // Read data lands one cycle after its issue, so samples 0..3 arrive in RD j=1..3 and PEND
  always_comb begin
    max_n = max_q;
    if (cs == S_RD && j == 2'd1)
      max_n = mem.cdata_rd;
    else if ((cs == S_RD && j != 2'd0) || cs == S_PEND)
      max_n = (mem.cdata_rd > max_q) ? mem.cdata_rd : max_q;
  end

  always_comb begin
    csel_n = CSEL_NONE;
    case (ns)
      S_RD:    csel_n = CSEL_L0_K0 + {2'b00, k_nxt};
      S_WL1:   csel_n = CSEL_L1_K0 + {2'b00, k_nxt};
      S_WL2:   csel_n = CSEL_L2;
      default: csel_n = CSEL_NONE;
    endcase
  end

  // Outputs are loaded from next-cycle state so every port is a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      cs           <= S_IDLE;
      max_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.crd      <= 1'b0;
      mem.caddr_rd <= '0;
      mem.cwr      <= 1'b0;
      mem.caddr_wr <= '0;
      mem.cdata_wr <= '0;
      mem.csel     <= CSEL_NONE;
    end else begin
      cs           <= ns;
      max_q        <= max_n;
      busy         <= (ns != S_IDLE) && (ns != S_DONE);
      done         <= (ns == S_DONE);
      mem.crd      <= (ns == S_RD);
      mem.caddr_rd <= (ns == S_RD) ? rd_addr_nxt : '0;
      mem.cwr      <= (ns == S_WL1) || (ns == S_WL2);
      mem.caddr_wr <= (ns == S_WL1) ? l1_addr_nxt : ((ns == S_WL2) ? l2_addr_nxt : '0);
      mem.cdata_wr <= ((ns == S_WL1) || (ns == S_WL2)) ? max_n : '0;
      mem.csel     <= csel_n;
    end
  end

endmodule
